// File: rtl/pipeline_control.sv
`default_nettype none
// +-----------------------------------------------------------------------------------+
// | pipeline_control : RV32I hazard, bypass and control decode; PERF_CNT_EN adds     |
// | saturating stall/flush counters.                                      Rev 1.0     |
// +-----------------------------------------------------------------------------------+
module pipeline_control #(
   parameter int NREGS = 32,
   parameter int ADDRW = $clog2(NREGS),
   parameter int CNTW  = 32
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_valid_d,
   input  logic [6:0]       i_opcode_d,
   input  logic [2:0]       i_funct3_d,
   input  logic [6:0]       i_funct7_d,
   input  logic [ADDRW-1:0] i_rs1_d,
   input  logic [ADDRW-1:0] i_rs2_d,
   input  logic [ADDRW-1:0] i_rd_d,
   input  logic             i_br_eq,
   input  logic             i_br_lt,
   output logic             o_stall_fd,
   output logic             o_flush_fd,
   output logic             o_pc_sel,
   output logic             o_br_un,
   output logic [1:0]       o_a_sel,
   output logic [1:0]       o_b_sel,
   output logic [1:0]       o_cmp1_sel,
   output logic [1:0]       o_cmp2_sel,
   output logic [3:0]       o_alu_sel,
   output logic             o_mem_rw,
   output logic [1:0]       o_wb_sel,
   output logic             o_reg_wen,
   output logic [ADDRW-1:0] o_rd_w
`ifdef PERF_CNT_EN
   ,
   output logic [CNTW-1:0]  o_stall_cnt,
   output logic [CNTW-1:0]  o_flush_cnt
`endif
);

   localparam logic [6:0] c_OP_LUI    = 7'b0110111;
   localparam logic [6:0] c_OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] c_OP_JAL    = 7'b1101111;
   localparam logic [6:0] c_OP_JALR   = 7'b1100111;
   localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
   localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
   localparam logic [6:0] c_OP_STORE  = 7'b0100011;
   localparam logic [6:0] c_OP_IMM    = 7'b0010011;
   localparam logic [6:0] c_OP_OP     = 7'b0110011;
   localparam logic [6:0] c_OP_SYSTEM = 7'b1110011;

   localparam logic [3:0] c_ALU_ADD = 4'd0, c_ALU_SUB = 4'd1, c_ALU_SLL = 4'd2, c_ALU_SRL = 4'd3;
   localparam logic [3:0] c_ALU_SRA = 4'd4, c_ALU_SLT = 4'd5, c_ALU_SLTU = 4'd6, c_ALU_XOR = 4'd7;
   localparam logic [3:0] c_ALU_OR  = 4'd8, c_ALU_AND = 4'd9, c_ALU_NOP = 4'd10;

   typedef struct packed {
      logic             valid;
      logic [6:0]       op;
      logic [2:0]       f3;
      logic [6:0]       f7;
      logic [ADDRW-1:0] rs1;
      logic [ADDRW-1:0] rs2;
      logic [ADDRW-1:0] rd;
   } stage_t;

   stage_t r_dx, r_xm, r_mw, w_dec;
   logic   w_cond, w_taken, w_load_use, w_unused;

   function automatic logic f_writes_reg(input stage_t s);
      return s.valid && (s.op != c_OP_STORE) && (s.op != c_OP_BRANCH) &&
             (s.op != c_OP_SYSTEM) && (s.rd != '0);
   endfunction

   function automatic logic f_rs1_used(input logic [6:0] op);
      return (op != c_OP_LUI) && (op != c_OP_AUIPC) && (op != c_OP_JAL);
   endfunction

   function automatic logic f_rs2_used(input logic [6:0] op);
      return (op == c_OP_OP) || (op == c_OP_STORE) || (op == c_OP_BRANCH);
   endfunction

   // Youngest producer wins: XM (11) over MW (10) over register file (00).
   function automatic logic [1:0] f_fwd(input logic [ADDRW-1:0] rs, input stage_t xm,
                                        input stage_t mw);
      if (f_writes_reg(xm) && xm.rd == rs)      return 2'b11;
      else if (f_writes_reg(mw) && mw.rd == rs) return 2'b10;
      else                                      return 2'b00;
   endfunction

   assign w_dec = {i_valid_d, i_opcode_d, i_funct3_d, i_funct7_d, i_rs1_d, i_rs2_d, i_rd_d};

   always_comb begin
      w_cond = 1'b0;
      case (r_dx.f3)
         3'b000:         w_cond = i_br_eq;
         3'b001:         w_cond = !i_br_eq;
         3'b100, 3'b110: w_cond = i_br_lt;
         3'b101, 3'b111: w_cond = !i_br_lt;
         default:        w_cond = 1'b0;
      endcase
      w_taken = r_dx.valid && ((r_dx.op == c_OP_JAL) || (r_dx.op == c_OP_JALR) ||
                               ((r_dx.op == c_OP_BRANCH) && w_cond));
      w_load_use = r_dx.valid && (r_dx.op == c_OP_LOAD) && (r_dx.rd != '0) && i_valid_d &&
                   ((f_rs1_used(i_opcode_d) && (i_rs1_d == r_dx.rd)) ||
                    (f_rs2_used(i_opcode_d) && (i_rs2_d == r_dx.rd)));
   end

   // A redirect kills the load-use stall: the dependent instruction is discarded anyway.
   assign o_flush_fd = w_taken;
   assign o_pc_sel   = w_taken;
   assign o_stall_fd = w_load_use && !w_taken;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_dx <= '0;
         r_xm <= '0;
         r_mw <= '0;
      end else begin
         r_dx <= (w_taken || w_load_use || !i_valid_d) ? '0 : w_dec;
         r_xm <= r_dx;
         r_mw <= r_xm;
      end
   end

   always_comb begin
      o_a_sel    = 2'b00;
      o_b_sel    = 2'b00;
      o_cmp1_sel = 2'b00;
      o_cmp2_sel = 2'b00;
      o_alu_sel  = c_ALU_NOP;
      o_br_un    = 1'b0;
      if (r_dx.valid) begin
         if (r_dx.op == c_OP_BRANCH || r_dx.op == c_OP_JAL || r_dx.op == c_OP_AUIPC)
            o_a_sel = 2'b01;
         else if (f_rs1_used(r_dx.op))
            o_a_sel = f_fwd(r_dx.rs1, r_xm, r_mw);
         o_b_sel = (r_dx.op == c_OP_OP) ? f_fwd(r_dx.rs2, r_xm, r_mw) : 2'b01;
         if (r_dx.op == c_OP_BRANCH) begin
            o_cmp1_sel = f_fwd(r_dx.rs1, r_xm, r_mw);
            o_cmp2_sel = f_fwd(r_dx.rs2, r_xm, r_mw);
            o_br_un    = (r_dx.f3 == 3'b110) || (r_dx.f3 == 3'b111);
         end
         case (r_dx.op)
            c_OP_AUIPC, c_OP_JAL, c_OP_JALR, c_OP_LOAD, c_OP_STORE, c_OP_BRANCH:
               o_alu_sel = c_ALU_ADD;
            c_OP_OP, c_OP_IMM: begin
               case (r_dx.f3)
                  3'd0: o_alu_sel = (r_dx.op == c_OP_OP && r_dx.f7 == 7'h20) ? c_ALU_SUB : c_ALU_ADD;
                  3'd1: o_alu_sel = c_ALU_SLL;
                  3'd2: o_alu_sel = c_ALU_SLT;
                  3'd3: o_alu_sel = c_ALU_SLTU;
                  3'd4: o_alu_sel = c_ALU_XOR;
                  3'd5: o_alu_sel = (r_dx.f7 == 7'h20) ? c_ALU_SRA : c_ALU_SRL;
                  3'd6: o_alu_sel = c_ALU_OR;
                  default: o_alu_sel = c_ALU_AND;
               endcase
            end
            default: o_alu_sel = c_ALU_NOP;
         endcase
      end
   end

   assign o_mem_rw  = r_xm.valid && (r_xm.op == c_OP_STORE);
   assign o_wb_sel  = !r_mw.valid                                   ? 2'd0 :
                      (r_mw.op == c_OP_LOAD)                         ? 2'd0 :
                      (r_mw.op == c_OP_JAL || r_mw.op == c_OP_JALR) ? 2'd2 : 2'd1;
   assign o_reg_wen = f_writes_reg(r_mw);
   assign o_rd_w    = r_mw.rd;
   assign w_unused  = ^{r_xm, r_mw};

`ifdef PERF_CNT_EN
   logic [CNTW-1:0] r_stall_cnt, r_flush_cnt;
   localparam logic [CNTW-1:0] c_CNT_ONE = {{(CNTW-1){1'b0}}, 1'b1};

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
      end else begin
         if (o_stall_fd && !(&r_stall_cnt)) r_stall_cnt <= r_stall_cnt + c_CNT_ONE;
         if (o_flush_fd && !(&r_flush_cnt)) r_flush_cnt <= r_flush_cnt + c_CNT_ONE;
      end
   end

   assign o_stall_cnt = r_stall_cnt;
   assign o_flush_cnt = r_flush_cnt;
`else
   logic [CNTW-1:0] w_unused_cnt;
   assign w_unused_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: doc/pipeline_control.md
PIPELINE_CONTROL -- requirements
Module: pipeline_control

Interface
REQ-001 Parameter NREGS, default 32, architectural register count (power of two, >=2).
REQ-002 Parameter ADDRW, default $clog2(NREGS), register address width.
REQ-003 Parameter CNTW, default 32, performance counter width.
REQ-004 clock  in  1  sole clock; all state updates on posedge.
REQ-005 reset  in  1  asynchronous, active-high; clears all state immediately.
REQ-006 valid_d, opcode_d, funct3_d, funct7_d  in  1/7/3/7  decode-stage instruction fields.
REQ-007 rs1_d, rs2_d, rd_d  in  ADDRW each  decode-stage register addresses.
REQ-008 br_eq, br_lt  in  1 each  EX-stage comparator results.
REQ-009 stall_fd  out  1  hold PC and FD register.
REQ-010 flush_fd  out  1  kill FD register contents.
REQ-011 pc_sel, br_un  out  1 each  redirect PC to EX target; unsigned compare.
REQ-012 a_sel, b_sel, cmp1_sel, cmp2_sel  out  2 each  operand selects: 00 REG, 01 PC (a) / IMM (b), 10 WX bypass, 11 MX bypass.
REQ-013 alu_sel  out  4  0 ADD, 1 SUB, 2 SLL, 3 SRL, 4 SRA, 5 SLT, 6 SLTU, 7 XOR, 8 OR, 9 AND, 10 NOP.
REQ-014 mem_rw, wb_sel  out  1/2  store enable; writeback select 0 MEM, 1 ALU, 2 PC4.
REQ-015 reg_wen, rd_w  out  1/ADDRW  writeback enable and destination.
REQ-016 stall_cnt, flush_cnt  out  CNTW each  present only with PERF_CNT_EN.

Function
REQ-017 Block owns DX, XM, MW stage registers, each holding valid, opcode, funct3, funct7, rs1, rs2, rd; all advance every cycle.
REQ-018 writes_reg(stage) = valid && opcode not store/branch/ecall && rd != 0.
REQ-019 Load-use: DX valid load, rd != 0, decode valid and uses matching rs1 (all but LUI/AUIPC/JAL) or rs2 (R-type, store, branch) -> stall_fd=1 that cycle, DX loads bubble (valid=0), XM/MW advance.
REQ-020 Taken = DX valid && (JAL || JALR || branch with BEQ/BNE/BLT/BGE/BLTU/BGEU condition true) -> pc_sel=1, flush_fd=1, DX loads bubble.
REQ-021 Taken and load-use in same cycle: flush wins, stall_fd=0.
REQ-022 Bypass priority MX (XM writes_reg, rd match) over WX (MW writes_reg, rd match) over REG; rd=0 never bypassed.
REQ-023 a_sel=01 for branch/JAL/AUIPC; b_sel=01 for all non-R-type; bypass applies to a_sel only when rs1 used, to b_sel only for R-type.
REQ-024 cmp1_sel/cmp2_sel follow REQ-022 for branches, else 00.
REQ-025 alu_sel: LUI NOP; AUIPC/JAL/JALR/load/store/branch ADD; SUB only R-type funct3=0 funct7=0x20; SRA when funct3=5 funct7=0x20 (R or I); unknown opcode NOP.
REQ-026 br_un=1 only for BLTU/BGEU.
REQ-027 All EX outputs gated by DX valid: invalid -> selects 00, alu_sel 10, pc_sel 0.
REQ-028 mem_rw = XM valid store; wb_sel MEM for load, PC4 for JAL/JALR, else ALU.
REQ-029 reg_wen = writes_reg(MW); rd_w = MW rd; latency decode->writeback 3 cycles.

Reset
REQ-030 Asserting reset clears all stage valids and counters asynchronously; outputs 0 except alu_sel=10.
REQ-031 Reset mid-stall or mid-flush abandons it; first post-reset cycle has no stall/flush.

Configuration
REQ-032 PERF_CNT_EN defined: stall_cnt increments per stall_fd cycle, flush_cnt per flush_fd cycle, both saturate at all-ones; undefined: ports and counters absent, other behaviour identical.

Verification
REQ-033 LW x5 then ADD x6,x5,x7 -> stall_fd=1 one cycle, bubble in DX, then a_sel=10 (WX).
REQ-034 ADD x3 then SUB x4,x3,x3 back-to-back -> a_sel=11, b_sel=11, alu_sel=1, no stall.
REQ-035 BEQ with br_eq=1 while load-use present -> pc_sel=1, flush_fd=1, stall_fd=0.
REQ-036 ADDI x0,x0,1 then ADD x1,x0,x0 -> no bypass (00), reg_wen=0 for x0.
REQ-037 reset pulsed during stall -> all outputs reset values immediately; with PERF_CNT_EN, 5 stalls -> stall_cnt=5.
